// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - memory controller req/done bus between the MEM stage and the controller
// The master side issues a held request; the slave answers with a one-cycle done pulse.
interface mem_stage_if;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [1:0]  mem_len_out;
  logic        mem_done_in;
  logic [31:0] mem_rdata_in;

  modport master (
    output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_len_out,
    input  mem_done_in, mem_rdata_in
  );

  modport slave (
    input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_len_out,
    output mem_done_in, mem_rdata_in
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: load/store handshake, load extension, ALU pass-through
// Stalls earlier stages while an access is outstanding; DONE lasts one cycle so EX/MEM advances.
module mem_stage #(
  parameter int               CMD_W   = 6,
  parameter logic [CMD_W-1:0] CMD_LB  = 6'd11,
  parameter logic [CMD_W-1:0] CMD_LH  = 6'd12,
  parameter logic [CMD_W-1:0] CMD_LW  = 6'd13,
  parameter logic [CMD_W-1:0] CMD_LBU = 6'd14,
  parameter logic [CMD_W-1:0] CMD_LHU = 6'd15,
  parameter logic [CMD_W-1:0] CMD_SB  = 6'd16,
  parameter logic [CMD_W-1:0] CMD_SH  = 6'd17,
  parameter logic [CMD_W-1:0] CMD_SW  = 6'd18
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic [CMD_W-1:0] cmdtype_in,
  input  logic [4:0]       rsd_addr_in,
  input  logic [31:0]      rsd_data_in,
  input  logic             write_rsd_in,
  input  logic [31:0]      mem_addr_in,
  input  logic [31:0]      store_data_in,
  mem_stage_if.master      mem,
  output logic             stall_req_out,
  output logic [4:0]       rsd_addr_out,
  output logic [31:0]      rsd_data_out,
  output logic             write_rsd_out
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_len;
  logic [31:0] r_load;

  logic        w_is_mem;
  logic        w_is_load;
  logic        w_is_store;
  logic [1:0]  w_len;
  logic [31:0] w_ext;

  assign w_is_mem   = (cmdtype_in >= CMD_LB) && (cmdtype_in <= CMD_SW);
  assign w_is_load  = (cmdtype_in >= CMD_LB) && (cmdtype_in <= CMD_LHU);
  assign w_is_store = (cmdtype_in >= CMD_SB) && (cmdtype_in <= CMD_SW);

  always_comb begin
    w_len = 2'd3;
    case (cmdtype_in)
      CMD_LB, CMD_LBU, CMD_SB: w_len = 2'd0;
      CMD_LH, CMD_LHU, CMD_SH: w_len = 2'd1;
      default:                 w_len = 2'd3;
    endcase
  end

  // EX/MEM is frozen during BUSY, so cmdtype_in still names the access being completed.
  always_comb begin
    w_ext = mem.mem_rdata_in;
    case (cmdtype_in)
      CMD_LB:  w_ext = {{24{mem.mem_rdata_in[7]}}, mem.mem_rdata_in[7:0]};
      CMD_LH:  w_ext = {{16{mem.mem_rdata_in[15]}}, mem.mem_rdata_in[15:0]};
      CMD_LBU: w_ext = {24'd0, mem.mem_rdata_in[7:0]};
      CMD_LHU: w_ext = {16'd0, mem.mem_rdata_in[15:0]};
      default: w_ext = mem.mem_rdata_in;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else if (rdy_in) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_is_mem) w_next = S_BUSY;
      S_BUSY:  if (mem.mem_done_in) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_len   <= 2'd0;
      r_load  <= 32'd0;
    end else if (rdy_in) begin
      if (r_state == S_IDLE && w_is_mem) begin
        r_req   <= 1'b1;
        r_we    <= w_is_store;
        r_addr  <= mem_addr_in;
        r_wdata <= store_data_in;
        r_len   <= w_len;
      end else if (r_state == S_BUSY && mem.mem_done_in) begin
        r_req  <= 1'b0;
        r_load <= w_ext;
      end
    end
  end

  always_comb begin
    stall_req_out = 1'b0;
    rsd_data_out  = rsd_data_in;
    write_rsd_out = 1'b0;
    case (r_state)
      S_IDLE: stall_req_out = w_is_mem;
      S_BUSY: stall_req_out = 1'b1;
      S_DONE: if (w_is_load) rsd_data_out = r_load;
      default: stall_req_out = 1'b0;
    endcase
    write_rsd_out = write_rsd_in && !stall_req_out && !(r_state == S_DONE && w_is_store);
  end

  assign rsd_addr_out      = rsd_addr_in;
  assign mem.mem_req_out   = r_req;
  assign mem.mem_we_out    = r_we;
  assign mem.mem_addr_out  = r_addr;
  assign mem.mem_wdata_out = r_wdata;
  assign mem.mem_len_out   = r_len;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed bench for mem_stage with a transaction-level reference model
// The model tracks "access outstanding" / "just completed" and checks every output each cycle.
module tb_mem_stage;
  localparam logic [5:0] LB = 6'd11, LH = 6'd12, LW = 6'd13, LBU = 6'd14, LHU = 6'd15;
  localparam logic [5:0] SB = 6'd16, SH = 6'd17, SW = 6'd18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic [5:0]  cmd = '0;
  logic [4:0]  rd = '0;
  logic [31:0] rdata_alu = '0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] sdata = '0;
  logic        stall;
  logic [4:0]  rd_o;
  logic [31:0] data_o;
  logic        wr_o;

  int checks = 0;
  int errors = 0;

  mem_stage_if u_if ();

  mem_stage u_dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .rdy_in        (rdy),
    .cmdtype_in    (cmd),
    .rsd_addr_in   (rd),
    .rsd_data_in   (rdata_alu),
    .write_rsd_in  (wr),
    .mem_addr_in   (addr),
    .store_data_in (sdata),
    .mem           (u_if),
    .stall_req_out (stall),
    .rsd_addr_out  (rd_o),
    .rsd_data_out  (data_o),
    .write_rsd_out (wr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish act=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit f_mem(input logic [5:0] c);
    return c >= LB && c <= SW;
  endfunction
  function automatic bit f_load(input logic [5:0] c);
    return c >= LB && c <= LHU;
  endfunction
  function automatic bit f_store(input logic [5:0] c);
    return c >= SB && c <= SW;
  endfunction
  function automatic logic [1:0] f_size(input logic [5:0] c);
    if (c == LB || c == LBU || c == SB) return 2'd0;
    if (c == LH || c == LHU || c == SH) return 2'd1;
    return 2'd3;
  endfunction
  function automatic logic [31:0] f_ext(input logic [5:0] c, input logic [31:0] r);
    int v;
    v = 0;
    case (c)
      LB:  begin v = int'(r % 256);   if (v >= 128)   v = v - 256;   end
      LH:  begin v = int'(r % 65536); if (v >= 32768) v = v - 65536; end
      LBU: v = int'(r % 256);
      LHU: v = int'(r % 65536);
      default: return r;
    endcase
    return 32'(v);
  endfunction

  // Reference model: which phase the current EX/MEM instruction's access is in.
  bit          m_out = 0;
  bit          m_fin = 0;
  logic        m_req = 0, m_we = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_val = 0;
  logic [1:0]  m_len = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_out = 0; m_fin = 0; m_req = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_len = 0; m_val = 0;
    end else if (rdy) begin
      if (m_fin) begin
        m_fin = 0;
      end else if (m_out) begin
        if (u_if.mem_done_in) begin
          m_out = 0; m_fin = 1; m_req = 0;
          m_val = f_ext(cmd, u_if.mem_rdata_in);
        end
      end else if (f_mem(cmd)) begin
        m_out = 1; m_req = 1; m_we = f_store(cmd);
        m_addr = addr; m_wdata = sdata; m_len = f_size(cmd);
      end
    end
  end

  always @(negedge clk) begin
    bit e_stall;
    e_stall = m_out || (!m_fin && f_mem(cmd));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("req", 32'(u_if.mem_req_out), 32'(m_req));
    chk("we", 32'(u_if.mem_we_out), 32'(m_we));
    chk("addr", u_if.mem_addr_out, m_addr);
    chk("wdata", u_if.mem_wdata_out, m_wdata);
    chk("len", 32'(u_if.mem_len_out), 32'(m_len));
    chk("rd", 32'(rd_o), 32'(rd));
    chk("data", data_o, (m_fin && f_load(cmd)) ? m_val : rdata_alu);
    chk("write", 32'(wr_o), 32'(wr && !e_stall && !(m_fin && f_store(cmd))));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic [5:0] c, input logic [4:0] r, input logic [31:0] d,
                        input logic w, input logic [31:0] a, input logic [31:0] s);
    cmd = c; rd = r; rdata_alu = d; wr = w; addr = a; sdata = s;
  endtask

  task automatic pulse_done(input logic [31:0] r);
    u_if.mem_done_in  = 1'b1;
    u_if.mem_rdata_in = r;
    step(1);
    u_if.mem_done_in  = 1'b0;
  endtask

  // One full access: issue, wait lat cycles in BUSY, done pulse, check the DONE cycle literally.
  task automatic mem_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] s,
                        input logic [31:0] r, input int lat, input logic [31:0] e_data,
                        input logic e_wr);
    set_in(c, 5'd7, 32'h0000_AAAA, 1'b1, a, s);
    #1;
    chk("lit_idle_req", 32'(u_if.mem_req_out), 32'd0);
    chk("lit_idle_stall", 32'(stall), 32'd1);
    step(1);
    chk("lit_busy_req", 32'(u_if.mem_req_out), 32'd1);
    chk("lit_busy_addr", u_if.mem_addr_out, a);
    step(lat);
    chk("lit_busy_held", 32'(u_if.mem_req_out), 32'd1);
    pulse_done(r);
    #1;
    chk("lit_done_data", data_o, e_data);
    chk("lit_done_write", 32'(wr_o), 32'(e_wr));
    chk("lit_done_stall", 32'(stall), 32'd0);
    chk("lit_done_req", 32'(u_if.mem_req_out), 32'd0);
    step(1);
    set_in(6'd0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    u_if.mem_done_in  = 1'b0;
    u_if.mem_rdata_in = 32'd0;
    step(2);
    chk("lit_rst_req", 32'(u_if.mem_req_out), 32'd0);
    chk("lit_rst_len", 32'(u_if.mem_len_out), 32'd0);
    chk("lit_rst_addr", u_if.mem_addr_out, 32'd0);
    rst = 1'b0;

    set_in(6'h01, 5'd5, 32'h1234, 1'b1, 32'd0, 32'd0);
    #1;
    chk("lit_alu_write", 32'(wr_o), 32'd1);
    chk("lit_alu_data", data_o, 32'h1234);
    chk("lit_alu_stall", 32'(stall), 32'd0);
    step(2);
    chk("lit_alu_req", 32'(u_if.mem_req_out), 32'd0);

    mem_op(LB, 32'h100, 32'd0, 32'h0000_00F0, 2, 32'hFFFF_FFF0, 1'b1);
    mem_op(LHU, 32'h104, 32'd0, 32'h0000_8001, 1, 32'h0000_8001, 1'b1);
    mem_op(LH, 32'h106, 32'd0, 32'h0000_8001, 0, 32'hFFFF_8001, 1'b1);
    mem_op(LBU, 32'h107, 32'd0, 32'h1234_5680, 1, 32'h0000_0080, 1'b1);
    mem_op(SW, 32'h2000, 32'hDEAD_BEEF, 32'd0, 2, 32'h0000_AAAA, 1'b0);
    mem_op(SW, 32'h2004, 32'h0BAD_F00D, 32'd0, 1, 32'h0000_AAAA, 1'b0);
    mem_op(SB, 32'h2001, 32'h0000_0077, 32'd0, 0, 32'h0000_AAAA, 1'b0);

    set_in(LW, 5'd9, 32'd0, 1'b1, 32'h3000, 32'd0);
    step(1);
    rdy = 1'b0;
    step(2);
    pulse_done(32'hCAFE_0001);
    step(1);
    chk("lit_frz_req", 32'(u_if.mem_req_out), 32'd1);
    chk("lit_frz_addr", u_if.mem_addr_out, 32'h3000);
    chk("lit_frz_len", 32'(u_if.mem_len_out), 32'd3);
    rdy = 1'b1;
    step(1);
    chk("lit_frz_busy", 32'(stall), 32'd1);
    pulse_done(32'h8765_4321);
    #1;
    chk("lit_lw_data", data_o, 32'h8765_4321);
    step(1);
    set_in(6'd0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    step(1);

    set_in(SH, 5'd3, 32'd0, 1'b0, 32'h4000, 32'h0000_5555);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    set_in(6'd0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("lit_abort_req", 32'(u_if.mem_req_out), 32'd0);
    chk("lit_abort_stall", 32'(stall), 32'd0);
    pulse_done(32'hFFFF_FFFF);
    step(1);
    chk("lit_late_req", 32'(u_if.mem_req_out), 32'd0);
    chk("lit_late_stall", 32'(stall), 32'd0);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
